car_traffic_controller: RTL and testbench
=========================================

// Module: car_traffic_controller
// PURPOSE
//  Produces the 16 car grid positions that the frog controller checks for collisions and the renderer draws.
//  Cars sit in 8 horizontal lanes, 2 cars per lane. Each lane steps its cars one column at a lane-specific, level-dependent rate.
//  Cars wrap around at the grid edges. Movement holds while the game is not running.
// PARAMETERS
//  GRID_COLS    20         columns; car x range 0..19
//  TICK_CYCLES  1_250_000  clk cycles per movement tick (50 ms at 25 MHz)
//  MIN_TICKS    1          floor on the lane step period, in ticks
//  FREEZE_TICKS 20         ticks that cars hold after freeze_req (CAR_FREEZE_EN only)
// PORTS
//  clk        in   1   system clock
//  reset_cars in   1   synchronous, active-high reset; restores the start layout
//  run        in   1   1 = traffic moves; 0 = positions and counters hold
//  level      in   4   current level 0..15; higher level = faster lanes
//  freeze_req in   1   1-cycle pulse on collision; ignored unless CAR_FREEZE_EN is defined
//  car_x_bus  out  80  car n x in bits [5n+4:5n], n = 0..15
//  car_y_bus  out  64  car n y in bits [4n+3:4n]
//  cars_moved out  1   1-cycle pulse in the same cycle the buses update
// BEHAVIOUR
//  Interface: one clock (clk); reset_cars is synchronous and active-high.
//  - Lane l (0..7) holds cars 2l and 2l+1. Lane rows are {13,12,11,10,8,7,6,5}; y never changes.
//  - Reset values: car 2l x = (3l) mod 20; car 2l+1 x = (3l+10) mod 20; y = lane row.
//    Also cars_moved = 0, all counters = 0, state = RUN.
//  - Prescaler counts 0..TICK_CYCLES-1 while run=1. The tick strobe fires on the terminal count.
//  - Lane tick counter lc[l] is 5 bits. period[l] = max(MIN_TICKS, BASE[l] - level), with BASE[l] = 4 + 2*(l mod 4).
//    The subtraction is saturating; it never underflows.
//  - On a tick in RUN: lc[l] increments. When lc[l]+1 >= period[l], the lane moves and lc[l] clears to 0.
//    Using >= means a level increase mid-count moves the lane on the next tick.
//  - Direction: even lanes move +1 (right), odd lanes move -1 (left).
//    Wrap-around: right from 19 goes to 0; left from 0 goes to 19.
//  - All outputs are registered. Moves take effect 1 cycle after the tick strobe.
//    cars_moved = 1 in that cycle if any lane moved.
//  - run=0: prescaler, lane counters and positions all freeze; cars_moved = 0.
//  - Priority: reset_cars > freeze_req > tick.
//    A tick in the same cycle as freeze_req produces no move.
//    reset_cars mid-operation restores the reset layout on the next edge regardless of state.
//  - State machine (under CAR_FREEZE_EN):
//    RUN -> FROZEN on freeze_req, loading the freeze counter with FREEZE_TICKS.
//    FROZEN decrements the freeze counter on each tick; lane counters hold.
//    FROZEN -> RUN when the counter reaches 0.
//    freeze_req while FROZEN reloads FREEZE_TICKS.
// CONFIGURATION
//  CAR_FREEZE_EN defined: freeze_req pauses all traffic for FREEZE_TICKS ticks after a collision.
//  CAR_FREEZE_EN undefined: no FROZEN state exists, freeze_req is ignored, and the block is always RUN.
// STRUCTURE
//  Package traffic_pkg holds:
//    GRID_COLS, GRID_ROWS = 15, NUM_CARS = 16, NUM_LANES = 8
//    col_t [4:0], row_t [3:0]
//    LANE_ROW[8], LANE_BASE[8], LANE_DIR[8] tables
//    reset-column function
//  Sub-module traffic_lane is instantiated 8 times. Each holds one lane's counter, its period compare
//  and its two car x registers with wrap logic.
//  The top level owns the prescaler, the freeze FSM and bus packing.
// TESTING (sim: TICK_CYCLES = 4, FREEZE_TICKS = 8)
//  1. Pulse reset_cars -> car0 = (0,13), car1 = (10,13), car2 = (3,12), car15 = (11,5); cars_moved = 0.
//  2. run=1, level=0, 16 cycles (4 ticks)
//     -> car0 x 0->1, car1 x 10->11, single cars_moved pulse; lane 1 (period 6) unmoved.
//  3. Lane 1 (left) from x=3: after 3 moves x=0, 4th move -> x=19.
//     Lane 0 car1 from 10 reaches 19, next move -> 0.
//  4. level=15 -> every lane moves on every tick; level 15->0 mid-count -> no move until lc reaches BASE.
//  5. run=0 for 100 cycles -> buses and cars_moved hold; run=1 resumes from the held counts.
//  6. CAR_FREEZE_EN: freeze_req -> no moves for 8 ticks, then moves resume.
//     Without the macro, moves continue through freeze_req.
//     reset_cars during FROZEN -> reset layout and RUN state.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared grid constants, lane tables, FSM states and reset layout helper
package traffic_pkg;
  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;
  localparam int NUM_CARS = 16;
  localparam int NUM_LANES = 8;
  typedef logic [4:0] col_t;
  typedef logic [3:0] row_t;
  typedef enum logic {RUN, FROZEN} state_t;
  localparam row_t LANE_ROW [NUM_LANES] = '{4'd13, 4'd12, 4'd11, 4'd10, 4'd8, 4'd7, 4'd6, 4'd5};
  localparam logic [4:0] LANE_BASE [NUM_LANES] = '{5'd4, 5'd6, 5'd8, 5'd10, 5'd4, 5'd6, 5'd8, 5'd10};
  // 1 = moves left, 0 = moves right
  localparam logic LANE_DIR [NUM_LANES] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  function automatic col_t reset_col(input int lane, input int car);
    return col_t'((3 * lane + 10 * car) % GRID_COLS);
  endfunction
endpackage

// File: rtl/car_traffic_controller_if.sv
// car_traffic_controller_if: control inputs (run, level, freeze_req) and car position outputs
// slave = controller side, master = game/driver side
interface car_traffic_controller_if;
  import traffic_pkg::*;
  logic run;
  logic [3:0] level;
  logic freeze_req;
  logic [5*NUM_CARS-1:0] car_x_bus;
  logic [4*NUM_CARS-1:0] car_y_bus;
  logic cars_moved;
  modport master (output run, level, freeze_req, input car_x_bus, car_y_bus, cars_moved);
  modport slave (input run, level, freeze_req, output car_x_bus, car_y_bus, cars_moved);
endinterface

// File: rtl/traffic_lane.sv
// traffic_lane: one lane's tick counter, level-dependent period compare and two wrapping car columns
// ports: clk, rst (sync), step (tick while running), level, x0/x1 car columns, move (lane steps this cycle)
module traffic_lane
  import traffic_pkg::*;
#(
  parameter int LANE = 0,
  parameter int MIN_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [3:0] level,
  output col_t       x0,
  output col_t       x1,
  output logic       move
);
  logic [4:0] lc, raw, period, lvl;
  logic [5:0] lc_inc;
  assign lvl = {1'b0, level};
  assign raw = lvl >= LANE_BASE[LANE] ? 5'd0 : LANE_BASE[LANE] - lvl;
  assign period = raw < 5'(MIN_TICKS) ? 5'(MIN_TICKS) : raw;
  assign lc_inc = {1'b0, lc} + 6'd1;
  // >= so that a period shortened mid-count fires on the next tick
  assign move = step && lc_inc >= {1'b0, period};
  function automatic col_t shift(input col_t x);
    return LANE_DIR[LANE] ? (x == '0 ? col_t'(GRID_COLS - 1) : x - 5'd1)
                          : (x == col_t'(GRID_COLS - 1) ? '0 : x + 5'd1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      lc <= '0;
      x0 <= reset_col(LANE, 0);
      x1 <= reset_col(LANE, 1);
    end else if (step) begin
      lc <= move ? '0 : lc_inc[4:0];
      if (move) begin
        x0 <= shift(x0);
        x1 <= shift(x1);
      end
    end
  end
endmodule

// File: rtl/car_traffic_controller.sv
// car_traffic_controller: moves 16 cars in 8 wrapping lanes at level-dependent rates
// ports: clk, reset_cars (sync, active-high), bus (slave: run, level, freeze_req -> car_x_bus, car_y_bus, cars_moved)
// CAR_FREEZE_EN: when defined, freeze_req pauses all traffic for FREEZE_TICKS ticks
module car_traffic_controller
  import traffic_pkg::*;
#(
  parameter int TICK_CYCLES = 1_250_000,
  parameter int MIN_TICKS = 1,
  parameter int FREEZE_TICKS = 20
) (
  input logic clk,
  input logic reset_cars,
  car_traffic_controller_if.slave bus
);
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [PW-1:0] pc;
  logic tick, step;
  logic [NUM_LANES-1:0] mv;
  col_t xs [NUM_CARS];
  assign tick = bus.run && pc == PW'(TICK_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset_cars) pc <= '0;
    else if (bus.run) pc <= tick ? '0 : pc + 1'b1;
  end
`ifdef CAR_FREEZE_EN
  localparam int FW = $clog2(FREEZE_TICKS + 1);
  state_t state, state_n;
  logic [FW-1:0] fc, fc_n;
  always_ff @(posedge clk) begin
    if (reset_cars) begin
      state <= RUN;
      fc <= '0;
    end else begin
      state <= state_n;
      fc <= fc_n;
    end
  end
  // freeze_req outranks a coincident tick, so that tick neither moves nor counts down
  always_comb begin
    state_n = state;
    fc_n = fc;
    step = 1'b0;
    if (bus.freeze_req) begin
      state_n = FROZEN;
      fc_n = FW'(FREEZE_TICKS);
    end else if (state == FROZEN) begin
      fc_n = tick ? fc - 1'b1 : fc;
      state_n = tick && fc == FW'(1) ? RUN : FROZEN;
    end else step = tick;
  end
`else
  assign step = tick;
`endif
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    traffic_lane #(.LANE(l), .MIN_TICKS(MIN_TICKS)) u_lane (
      .clk(clk), .rst(reset_cars), .step(step), .level(bus.level),
      .x0(xs[2*l]), .x1(xs[2*l+1]), .move(mv[l])
    );
    assign bus.car_y_bus[8*l +: 8] = {LANE_ROW[l], LANE_ROW[l]};
  end
  for (genvar n = 0; n < NUM_CARS; n++) begin : g_x
    assign bus.car_x_bus[5*n +: 5] = xs[n];
  end
  always_ff @(posedge clk) begin
    if (reset_cars) bus.cars_moved <= 1'b0;
    else bus.cars_moved <= |mv;
  end
endmodule

// File: tb/tb_car_traffic_controller.sv
// tb_car_traffic_controller: table vectors, corner sequences and random run against a behavioural model
module tb_car_traffic_controller;
  import traffic_pkg::*;
  localparam int TICK = 4;
  localparam int FRZ = 8;
  logic clk = 1'b0;
  logic reset_cars = 1'b0;
  always #5 clk = ~clk;
  car_traffic_controller_if bus();
  car_traffic_controller #(.TICK_CYCLES(TICK), .MIN_TICKS(1), .FREEZE_TICKS(FRZ)) dut (
    .clk(clk), .reset_cars(reset_cars), .bus(bus)
  );
  int passed = 0, total = 0, pulses = 0;
  int pos [16];
  int lt [8];
  int pc, frozen;
  bit m_moved;
  int rows [8] = '{13, 12, 11, 10, 8, 7, 6, 5};
  typedef struct {bit rst; bit run; int level; int cycles; int x0; int x2; int pulses;} vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic model_reset();
    for (int l = 0; l < 8; l++) begin
      pos[2*l] = (3 * l) % 20;
      pos[2*l+1] = (3 * l + 10) % 20;
      lt[l] = 0;
    end
    pc = 0;
    frozen = 0;
    m_moved = 0;
  endtask
  task automatic model_step();
    bit tick;
    if (reset_cars) begin
      model_reset();
      return;
    end
    m_moved = 0;
    tick = 0;
    if (bus.run) begin
      tick = (pc == TICK - 1);
      pc = (pc + 1) % TICK;
    end
`ifdef CAR_FREEZE_EN
    if (bus.freeze_req) begin
      frozen = FRZ;
      tick = 0;
    end else if (tick && frozen > 0) begin
      frozen--;
      tick = 0;
    end
`endif
    if (tick) for (int l = 0; l < 8; l++) begin
      int per, d;
      per = 4 + 2 * (l % 4) - int'(bus.level);
      if (per < 1) per = 1;
      d = (l % 2) ? -1 : 1;
      lt[l]++;
      if (lt[l] >= per) begin
        lt[l] = 0;
        m_moved = 1;
        pos[2*l] = (pos[2*l] + d + 20) % 20;
        pos[2*l+1] = (pos[2*l+1] + d + 20) % 20;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    pulses += int'(bus.cars_moved);
  endtask
  function automatic int cx(input int n);
    return int'(bus.car_x_bus[5*n +: 5]);
  endfunction
  function automatic int cy(input int n);
    return int'(bus.car_y_bus[4*n +: 4]);
  endfunction
  task automatic do_reset();
    reset_cars = 1'b1;
    cyc();
    reset_cars = 1'b0;
    pulses = 0;
  endtask
  task automatic run_n(input int n);
    repeat (n) cyc();
  endtask
  initial begin
    logic [79:0] ex;
    logic [63:0] ey;
    bus.run = 1'b0;
    bus.level = 4'd0;
    bus.freeze_req = 1'b0;
    do_reset();
    chk("reset car0 x", 80'(cx(0)), 80'd0);
    chk("reset car0 y", 80'(cy(0)), 80'd13);
    chk("reset car1 x", 80'(cx(1)), 80'd10);
    chk("reset car2 x", 80'(cx(2)), 80'd3);
    chk("reset car2 y", 80'(cy(2)), 80'd12);
    chk("reset car15 x", 80'(cx(15)), 80'd11);
    chk("reset car15 y", 80'(cy(15)), 80'd5);
    chk("reset moved", 80'(bus.cars_moved), 80'd0);
    bus.run = 1'b1;
    run_n(16);
    chk("4 ticks car0", 80'(cx(0)), 80'd1);
    chk("4 ticks car1", 80'(cx(1)), 80'd11);
    chk("4 ticks car2 held", 80'(cx(2)), 80'd3);
    chk("4 ticks pulses", 80'(pulses), 80'd1);
    run_n(56);
    chk("lane1 at 0", 80'(cx(2)), 80'd0);
    run_n(24);
    chk("lane1 wrap 19", 80'(cx(2)), 80'd19);
    run_n(48);
    chk("car1 at 19", 80'(cx(1)), 80'd19);
    run_n(16);
    chk("car1 wrap 0", 80'(cx(1)), 80'd0);
    tbl[0] = '{1, 0, 0, 1, 0, 3, 0};
    tbl[1] = '{0, 1, 15, 8, 2, 1, 2};
    tbl[2] = '{0, 0, 15, 100, 2, 1, 0};
    tbl[3] = '{0, 1, 0, 12, 2, 1, 0};
    tbl[4] = '{0, 1, 0, 4, 3, 1, 1};
    tbl[5] = '{0, 1, 0, 8, 3, 0, 1};
    tbl[6] = '{0, 1, 0, 4, 3, 0, 0};
    tbl[7] = '{0, 1, 3, 4, 4, 0, 1};
    tbl[8] = '{0, 1, 15, 4, 5, 19, 1};
    for (int i = 0; i < 9; i++) begin
      reset_cars = tbl[i].rst;
      bus.run = tbl[i].run;
      bus.level = 4'(tbl[i].level);
      pulses = 0;
      run_n(tbl[i].cycles);
      reset_cars = 1'b0;
      chk($sformatf("vec%0d car0", i), 80'(cx(0)), 80'(tbl[i].x0));
      chk($sformatf("vec%0d car2", i), 80'(cx(2)), 80'(tbl[i].x2));
      chk($sformatf("vec%0d pulses", i), 80'(pulses), 80'(tbl[i].pulses));
    end
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    bus.level = 4'd15;
    bus.freeze_req = 1'b1;
    cyc();
    bus.freeze_req = 1'b0;
    run_n(31);
`ifdef CAR_FREEZE_EN
    chk("frozen car0", 80'(cx(0)), 80'd0);
    chk("frozen pulses", 80'(pulses), 80'd0);
    run_n(4);
    chk("thaw car0", 80'(cx(0)), 80'd1);
    chk("thaw pulses", 80'(pulses), 80'd1);
`else
    chk("no freeze car0", 80'(cx(0)), 80'd8);
    chk("no freeze pulses", 80'(pulses), 80'd8);
    run_n(4);
    chk("no freeze car0 +1", 80'(cx(0)), 80'd9);
    chk("no freeze pulses +1", 80'(pulses), 80'd9);
`endif
    bus.freeze_req = 1'b1;
    cyc();
    bus.freeze_req = 1'b0;
    run_n(5);
    do_reset();
    chk("reset in frozen car0", 80'(cx(0)), 80'd0);
    chk("reset in frozen car1", 80'(cx(1)), 80'd10);
    run_n(4);
    chk("run after reset car0", 80'(cx(0)), 80'd1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.run = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) bus.level = 4'($urandom_range(0, 15));
      bus.freeze_req = $urandom_range(0, 99) == 0;
      reset_cars = $urandom_range(0, 999) == 0;
      cyc();
      for (int n = 0; n < 16; n++) begin
        ex[5*n +: 5] = 5'(pos[n]);
        ey[4*n +: 4] = 4'(rows[n/2]);
      end
      chk($sformatf("rand x c%0d", c), bus.car_x_bus, ex);
      chk($sformatf("rand y c%0d", c), 80'(bus.car_y_bus), 80'(ey));
      chk($sformatf("rand moved c%0d", c), 80'(bus.cars_moved), 80'(m_moved));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
